// File: rtl/fp9_convert_seq.sv
// Time-multiplexed FP4/FP8/FP16 -> FP9 (E5M3, bias 15) word converter, one element per cycle.
// Define FP9_SEQ_FLAGS_EN to instantiate the sticky exception flags; otherwise flag_* are tied to 0.
module fp9_convert_seq #(
  parameter int IN_WIDTH = 32,
  parameter int MAX_ELEM = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [4:0]            type_cd_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9*MAX_ELEM-1:0] out_data,
  output logic [3:0]            out_count,
  output logic                  flag_invalid,
  output logic                  flag_overflow,
  output logic                  flag_underflow
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                r_state, w_next;
  logic [IN_WIDTH-1:0]   r_data;
  logic [1:0]            r_type;
  logic [2:0]            r_idx, r_last, w_last;
  logic [3:0]            r_cnt, w_cnt;
  logic [9*MAX_ELEM-1:0] r_res;
  logic                  w_acc, w_bad, w_nan;
  logic [3:0]            w_e4;
  logic [7:0]            w_e8;
  logic [15:0]           w_e16;
  logic [8:0]            w_res;

  assign w_acc = in_valid && in_ready;
  assign w_bad = (type_cd_i > 5'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = w_bad ? DONE : CONV;
      CONV:    if (r_idx == r_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_comb begin
    w_cnt  = 4'd0;
    w_last = 3'd0;
    case (type_cd_i)
      5'd0:    begin w_cnt = 4'd8; w_last = 3'd7; end
      5'd1:    begin w_cnt = 4'd4; w_last = 3'd3; end
      5'd2:    begin w_cnt = 4'd2; w_last = 3'd1; end
      default: begin w_cnt = 4'd0; w_last = 3'd0; end
    endcase
  end

  assign w_e4  = r_data[{r_idx, 2'b00} +: 4];
  assign w_e8  = r_data[{r_idx[1:0], 3'b000} +: 8];
  assign w_e16 = r_data[{r_idx[0], 4'b0000} +: 16];

  // E4M3 has no infinity: only S.1111.111 is NaN, the rest of exponent 15 is normal.
  always_comb begin
    w_nan = 1'b0;
    case (r_type)
      2'd1:    w_nan = (w_e8[6:0] == 7'h7F);
      2'd2:    w_nan = (w_e16[14:10] == 5'h1F) && (w_e16[9:0] != 10'd0);
      default: w_nan = 1'b0;
    endcase
  end

  always_comb begin
    w_res = 9'd0;
    case (r_type)
      2'd0: begin
        if (w_e4[2:1] == 2'd0) w_res = {w_e4[3], (w_e4[0] ? 5'd14 : 5'd0), 3'b000};
        else                   w_res = {w_e4[3], 5'({3'b000, w_e4[2:1]}) + 5'd14, w_e4[0], 2'b00};
      end
      2'd1: begin
        if (w_e8[6:3] != 4'd0)  w_res = {w_e8[7], 5'({1'b0, w_e8[6:3]}) + 5'd8, w_e8[2:0]};
        else if (w_e8[2])       w_res = {w_e8[7], 5'd8, w_e8[1:0], 1'b0};
        else if (w_e8[1])       w_res = {w_e8[7], 5'd7, w_e8[0], 2'b00};
        else if (w_e8[0])       w_res = {w_e8[7], 5'd6, 3'b000};
        else                    w_res = {w_e8[7], 8'd0};
      end
      2'd2: begin
        // Same exponent range: FP16 subnormals land directly on FP9 subnormals.
        if (w_e16[14:10] == 5'h1F) w_res = {w_e16[15], 8'hF8};
        else                       w_res = {w_e16[15], w_e16[14:10], w_e16[9:7]};
      end
      default: w_res = 9'd0;
    endcase
    if (w_nan) w_res = {w_res[8], 8'hFC};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_type <= 2'd0;
      r_idx  <= 3'd0;
      r_last <= 3'd0;
      r_cnt  <= 4'd0;
      r_res  <= '0;
    end else if (w_acc) begin
      r_data <= in_data;
      r_type <= type_cd_i[1:0];
      r_idx  <= 3'd0;
      r_last <= w_last;
      r_cnt  <= w_cnt;
      r_res  <= '0;
    end else if (r_state == CONV) begin
      r_res[7'(r_idx) * 7'd9 +: 9] <= w_res;
      if (r_idx != r_last) r_idx <= r_idx + 3'd1;
    end
  end

  assign out_data  = r_res;
  assign out_count = r_cnt;
  // Every source exponent range fits inside E5, so the converter never overflows.
  assign flag_overflow = 1'b0;

`ifdef FP9_SEQ_FLAGS_EN
  logic r_inv, r_unf, w_tiny;

  assign w_tiny = (r_type == 2'd2) && (w_e16[14:10] == 5'd0) && (w_e16[9:0] != 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_acc) begin
      r_inv <= w_bad;
      r_unf <= 1'b0;
    end else if (r_state == CONV) begin
      r_inv <= r_inv | w_nan;
      r_unf <= r_unf | w_tiny;
    end
  end

  assign flag_invalid   = r_inv;
  assign flag_underflow = r_unf;
`else
  assign flag_invalid   = 1'b0;
  assign flag_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fp9_convert_seq.sv
// Directed plus random words checked against a real-arithmetic FP9 reference model.
module tb_fp9_convert_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  type_cd_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_data;
  logic [3:0]  out_count;
  logic        flag_invalid, flag_overflow, flag_underflow;

  int n_vec = 0;
  int n_err = 0;
  logic [71:0] got_d;

  fp9_convert_seq #(.IN_WIDTH(32), .MAX_ELEM(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .type_cd_i(type_cd_i), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Decode to a real value, then re-encode as E5M3 with truncation.
  function automatic void ref_conv(input int t, input logic [15:0] b,
                                   output logic [8:0] r, output bit inv, output bit unf);
    real v;
    bit  s;
    int  e, m;
    inv = 0; unf = 0; r = '0; v = 0.0; s = 0;
    case (t)
      0: begin
        s = b[3]; e = int'(b[2:1]); m = int'(b[0]);
        v = (e == 0) ? m * 0.5 : p2(e - 1) * (1.0 + m / 2.0);
      end
      1: begin
        s = b[7]; e = int'(b[6:3]); m = int'(b[2:0]);
        if (e == 15 && m == 7) begin r = {s, 8'hFC}; inv = 1; return; end
        v = (e == 0) ? (m / 8.0) * p2(-6) : p2(e - 7) * (1.0 + m / 8.0);
      end
      default: begin
        s = b[15]; e = int'(b[14:10]); m = int'(b[9:0]);
        if (e == 31) begin
          if (m == 0) r = {s, 8'hF8};
          else begin r = {s, 8'hFC}; inv = 1; end
          return;
        end
        v = (e == 0) ? (m / 1024.0) * p2(-14) : p2(e - 15) * (1.0 + m / 1024.0);
      end
    endcase
    if (v == 0.0) r = {s, 8'h00};
    else if (v < p2(-14)) begin
      unf = 1;
      r = {s, 5'd0, 3'($rtoi(v * p2(17)))};
    end else begin
      e = 0;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      r = {s, 5'(e + 15), 3'($rtoi((v - 1.0) * 8.0))};
    end
  endfunction

  function automatic void ref_word(input logic [31:0] d, input int t, output logic [71:0] od,
                                   output logic [3:0] cnt, output bit inv, output bit unf);
    int n, w;
    logic [8:0] r;
    bit ei, eu;
    logic [31:0] sh;
    od = '0; inv = 0; unf = 0;
    if (t > 2) begin
      cnt = 4'd0; inv = 1;
    end else begin
      n = 8 >> t; w = 4 << t; cnt = 4'(n);
      for (int k = 0; k < n; k++) begin
        sh = d >> (k * w);
        ref_conv(t, sh[15:0] & 16'((1 << w) - 1), r, ei, eu);
        od[k*9 +: 9] = r;
        inv |= ei; unf |= eu;
      end
    end
`ifndef FP9_SEQ_FLAGS_EN
    inv = 0; unf = 0;
`endif
  endfunction

  task automatic run_word(input logic [31:0] d, input int t, input int bp, input bit pulse);
    logic [71:0] ed;
    logic [3:0]  ec;
    bit          ei, eu;
    int          lat;
    ref_word(d, t, ed, ec, ei, eu);
    @(negedge clk);
    chk("in_ready_idle", 72'(in_ready), 72'(1));
    in_valid = 1; in_data = d; type_cd_i = 5'(t);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 0; in_data = $urandom; type_cd_i = 5'($urandom);
    while (!out_valid && lat < 40) begin
      chk("in_ready_conv", 72'(in_ready), 72'(0));
      @(posedge clk); lat++;
      @(negedge clk); in_data = $urandom;
    end
    chk("latency", 72'(lat), 72'((t > 2) ? 1 : (8 >> t) + 1));
    chk("out_valid", 72'(out_valid), 72'(1));
    chk("out_data", out_data, ed);
    chk("out_count", 72'(out_count), 72'(ec));
    chk("flag_invalid", 72'(flag_invalid), 72'(ei));
    chk("flag_underflow", 72'(flag_underflow), 72'(eu));
    chk("flag_overflow", 72'(flag_overflow), 72'(0));
    chk("in_ready_done", 72'(in_ready), 72'(0));
    for (int i = 0; i < bp; i++) begin
      if (pulse) begin in_valid = ~in_valid; in_data = $urandom; type_cd_i = 5'd1; end
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", 72'(out_valid), 72'(1));
      chk("bp_data", out_data, ed);
      chk("bp_count", 72'(out_count), 72'(ec));
      chk("bp_flag", 72'({flag_invalid, flag_underflow}), 72'({ei, eu}));
      chk("bp_in_ready", 72'(in_ready), 72'(0));
    end
    in_valid = 0;
    got_d = out_data;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk("ready_after_hs", 72'(in_ready), 72'(1));
    chk("valid_after_hs", 72'(out_valid), 72'(0));
  endtask

  initial begin
    int t;
    // Reset state
    #1;
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_out_data", out_data, 72'(0));
    chk("rst_out_count", 72'(out_count), 72'(0));
    chk("rst_flags", 72'({flag_invalid, flag_overflow, flag_underflow}), 72'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Directed words
    run_word(32'h3838_007F, 1, 0, 0);
    chk("plan_fp8", got_d, {36'd0, 9'h078, 9'h078, 9'h000, 9'h0FC});
    run_word(32'hBC00_3C00, 2, 0, 0);
    chk("plan_fp16", got_d, {54'd0, 9'h178, 9'h078});
    run_word(32'h2222_2222, 0, 0, 0);
    chk("plan_fp4", got_d, {8{9'h078}});
    run_word(32'h0001_83FF, 2, 0, 0);
    run_word(32'h0102_0304, 1, 0, 0);
    run_word(32'hFC00_7C00, 2, 0, 0);
    run_word(32'h89AB_CDEF, 0, 0, 0);

    // Back-pressure with ignored input pulses, then unsupported type
    run_word(32'h4080_C0FF, 1, 10, 1);
    run_word(32'h1234_5678, 5, 3, 0);

    // Reset during FP4 conversion at index 3
    @(negedge clk);
    in_valid = 1; in_data = 32'h2222_2222; type_cd_i = 5'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_valid", 72'(out_valid), 72'(0));
    chk("midrst_ready", 72'(in_ready), 72'(1));
    chk("midrst_data", out_data, 72'(0));
    chk("midrst_count", 72'(out_count), 72'(0));
    chk("midrst_flags", 72'({flag_invalid, flag_overflow, flag_underflow}), 72'(0));
    @(negedge clk);
    rst_n = 1;
    run_word(32'h3838_007F, 1, 0, 0);

    // Random words
    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 9);
      if (t > 2) t = (t == 9) ? $urandom_range(3, 31) : $urandom_range(0, 2);
      run_word($urandom, t, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
